// File: rtl/irq_pkg.sv
// ---------------------------------------------------------------------------
// irq_pkg
//
// Purpose: shared types, constants and a helper function for the machine
// external interrupt controller (irq_ctrl) and its per-source gateway
// (irq_gateway).
//
// Contents:
//   irq_gw_state_t - gateway state (IDLE, PENDING, CLAIMED)
//   IRQ_PENDING    - byte offset of the read-only pending register
//   IRQ_ENABLE     - byte offset of the enable register
//   IRQ_TRIGGER    - byte offset of the trigger-type register
//   IRQ_CLAIM      - byte offset of the claim (read) / complete (write) port
//   irq_first_id   - lowest set bit index plus one, or 0 when no bit is set
// ---------------------------------------------------------------------------
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    CLAIMED = 2'd2
  } irq_gw_state_t;

  localparam logic [3:0] IRQ_PENDING = 4'h0;
  localparam logic [3:0] IRQ_ENABLE  = 4'h4;
  localparam logic [3:0] IRQ_TRIGGER = 4'h8;
  localparam logic [3:0] IRQ_CLAIM   = 4'hC;

  // Scanning from the top down and overwriting leaves the lowest set index,
  // which is the highest-priority source. Ids are 1-based so that 0 can mean
  // "nothing to claim".
  function automatic logic [5:0] irq_first_id(input logic [31:0] i_vec);
    logic [5:0] v_id;
    v_id = '0;
    for (int i = 31; i >= 0; i--) begin
      if (i_vec[i]) begin
        v_id = 6'(i + 1);
      end
    end
    return v_id;
  endfunction

endpackage

// File: rtl/irq_gateway.sv
// ---------------------------------------------------------------------------
// irq_gateway
//
// Purpose: per-source interrupt gateway. Samples one raw request line
// (optionally through a two-flop synchronizer), detects rising edges, and
// runs the IDLE / PENDING / CLAIMED state machine plus the rearm flag that
// remembers an edge seen while the source was being serviced.
//
// Configuration:
//   IRQ_CTRL_SYNC_EN - when defined, i_SRC passes through a two-flop
//                      synchronizer before the sample flop (3-cycle latency);
//                      otherwise i_SRC is sampled directly (1-cycle latency).
//
// Ports:
//   i_CLK       - clock
//   i_RSTn      - asynchronous active-low reset
//   i_SRC       - raw interrupt request, active-high
//   i_TRIG      - trigger type: 1 = rising edge, 0 = level
//   i_TRIG_CHG  - one-cycle strobe, trigger type is being changed
//   i_CLAIM     - one-cycle strobe, this source is being claimed
//   i_COMPLETE  - one-cycle strobe, this source is being completed
//   o_PENDING   - registered flag, state is PENDING
//   o_CLAIMED   - registered flag, state is CLAIMED
// ---------------------------------------------------------------------------
module irq_gateway
  import irq_pkg::*;
(
  input  logic i_CLK,
  input  logic i_RSTn,
  input  logic i_SRC,
  input  logic i_TRIG,
  input  logic i_TRIG_CHG,
  input  logic i_CLAIM,
  input  logic i_COMPLETE,
  output logic o_PENDING,
  output logic o_CLAIMED
);

  logic          r_samp;
  logic          r_hist;
  logic          r_rearm;
  logic          r_pending;
  logic          r_claimed;
  irq_gw_state_t r_state;
  irq_gw_state_t w_next;
  logic          w_rearmNext;
  logic          w_rise;

`ifdef IRQ_CTRL_SYNC_EN
  logic [1:0] r_sync;

  // Two-flop synchronizer in front of the sample flop so the source may be
  // asynchronous to i_CLK. The sample and history flops then see a clean
  // synchronous signal for edge detection.
  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      r_sync <= '0;
      r_samp <= 1'b0;
      r_hist <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_SRC};
      r_samp <= r_sync[1];
      r_hist <= r_samp;
    end
  end
`else
  // The source is already synchronous to i_CLK, so it is sampled directly.
  // The history flop holds the previous sample for edge detection.
  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      r_samp <= 1'b0;
      r_hist <= 1'b0;
    end else begin
      r_samp <= i_SRC;
      r_hist <= r_samp;
    end
  end
`endif

  assign w_rise = r_samp & ~r_hist;

  // Next-state logic for the gateway. A claim takes priority over a level
  // source dropping in the same cycle. On complete, a remembered edge
  // (rearm) or an edge arriving in that very cycle sends the source straight
  // back to PENDING; otherwise it rests in IDLE and a still-high level input
  // is picked up again from IDLE on the following cycle. A trigger-type
  // change always discards a remembered edge.
  always_comb begin
    w_next      = r_state;
    w_rearmNext = r_rearm;
    case (r_state)
      IDLE: begin
        if (i_TRIG ? w_rise : r_samp) begin
          w_next = PENDING;
        end
      end
      PENDING: begin
        if (i_CLAIM) begin
          w_next = CLAIMED;
        end else if (!i_TRIG && !r_samp) begin
          w_next = IDLE;
        end
      end
      CLAIMED: begin
        if (i_COMPLETE) begin
          w_next      = (r_rearm || w_rise) ? PENDING : IDLE;
          w_rearmNext = 1'b0;
        end else if (i_TRIG && w_rise) begin
          w_rearmNext = 1'b1;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
    if (i_TRIG_CHG) begin
      w_rearmNext = 1'b0;
    end
  end

  // State, rearm flag and the registered pending/claimed flags all update
  // together so the flags never lag the state they describe.
  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      r_state   <= IDLE;
      r_rearm   <= 1'b0;
      r_pending <= 1'b0;
      r_claimed <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_rearm   <= w_rearmNext;
      r_pending <= (w_next == PENDING);
      r_claimed <= (w_next == CLAIMED);
    end
  end

  assign o_PENDING = r_pending;
  assign o_CLAIMED = r_claimed;

endmodule

// File: rtl/irq_ctrl.sv
// ---------------------------------------------------------------------------
// irq_ctrl
//
// Purpose: machine external interrupt controller. One irq_gateway per source
// holds the pending/claimed state; this level owns the register port
// (PENDING, ENABLE, TRIGGER, CLAIM/COMPLETE), the ENABLE and TRIGGER
// registers and the lowest-index-wins priority encoder used by claims.
//
// Configuration:
//   IRQ_CTRL_SYNC_EN - when defined, every source goes through a two-flop
//                      synchronizer inside its gateway (3-cycle latency);
//                      default build samples sources directly (1 cycle).
//
// Ports:
//   N_SRC        - number of interrupt sources, 1..31
//   i_CLK        - clock
//   i_RSTn       - asynchronous active-low reset
//   i_SRC        - raw peripheral requests, active-high
//   i_BUS_EN     - one-cycle register access request
//   i_BUS_WE     - 1 = write, 0 = read
//   i_BUS_ADDR   - byte address, [3:2] selects the word
//   i_BUS_WDATA  - write data
//   o_BUS_RDATA  - registered read data
//   o_BUS_ACK    - one-cycle access-done pulse
//   o_MEI        - per-source interrupt level to the core
// ---------------------------------------------------------------------------
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int N_SRC = 6
) (
  input  logic             i_CLK,
  input  logic             i_RSTn,
  input  logic [N_SRC-1:0] i_SRC,
  input  logic             i_BUS_EN,
  input  logic             i_BUS_WE,
  input  logic [3:0]       i_BUS_ADDR,
  input  logic [31:0]      i_BUS_WDATA,
  output logic [31:0]      o_BUS_RDATA,
  output logic             o_BUS_ACK,
  output logic [N_SRC-1:0] o_MEI
);

  logic [N_SRC-1:0] r_enable;
  logic [N_SRC-1:0] r_trig;
  logic [31:0]      r_rdata;
  logic             r_ack;

  logic [N_SRC-1:0] w_pending;
  logic [N_SRC-1:0] w_claimed;
  logic [N_SRC-1:0] w_qual;
  logic [N_SRC-1:0] w_claimStb;
  logic [N_SRC-1:0] w_compStb;
  logic [N_SRC-1:0] w_trigChg;
  logic [5:0]       w_claimId;
  logic [3:0]       w_word;
  logic             w_isRead;
  logic             w_isWrite;
  logic             w_claimRd;
  logic             w_compWr;
  logic [31:0]      w_rdata;
  logic             w_unusedAddr;
  logic             w_unusedClaimed;

  assign w_word          = {i_BUS_ADDR[3:2], 2'b00};
  assign w_unusedAddr    = &{1'b0, i_BUS_ADDR[1:0]};
  assign w_unusedClaimed = &{1'b0, w_claimed};
  assign w_isRead        = i_BUS_EN & ~i_BUS_WE;
  assign w_isWrite       = i_BUS_EN & i_BUS_WE;
  assign w_claimRd       = w_isRead && (w_word == IRQ_CLAIM);
  assign w_compWr        = w_isWrite && (w_word == IRQ_CLAIM);

  // Only pending sources that are enabled compete for a claim. The id is
  // computed from the current (pre-edge) gateway state, so a source that
  // becomes pending at the same clock edge is not claimed by that read.
  assign w_qual    = w_pending & r_enable;
  assign w_claimId = irq_first_id({{(32 - N_SRC){1'b0}}, w_qual});

  // A trigger write only disturbs the sources whose trigger bit actually
  // changes; their rearm flags are dropped inside the gateway.
  assign w_trigChg = (w_isWrite && (w_word == IRQ_TRIGGER))
                   ? (i_BUS_WDATA[N_SRC-1:0] ^ r_trig) : '0;

  // One gateway per source. Claim and complete strobes are one-hot: a claim
  // goes only to the winning source, and a complete goes to the source whose
  // id matches the full write data, so ids of 0 or above N_SRC hit nothing.
  for (genvar g = 0; g < N_SRC; g++) begin : g_src
    assign w_claimStb[g] = w_claimRd && (w_claimId == 6'(g + 1));
    assign w_compStb[g]  = w_compWr && (i_BUS_WDATA == 32'(g + 1));

    irq_gateway u_gateway (
      .i_CLK      (i_CLK),
      .i_RSTn     (i_RSTn),
      .i_SRC      (i_SRC[g]),
      .i_TRIG     (r_trig[g]),
      .i_TRIG_CHG (w_trigChg[g]),
      .i_CLAIM    (w_claimStb[g]),
      .i_COMPLETE (w_compStb[g]),
      .o_PENDING  (w_pending[g]),
      .o_CLAIMED  (w_claimed[g])
    );
  end

  // Read-data mux for the register map. Bits above N_SRC and the unused
  // upper bits of the claim id read as zero.
  always_comb begin
    w_rdata = '0;
    case (w_word)
      IRQ_PENDING: w_rdata = {{(32 - N_SRC){1'b0}}, w_pending};
      IRQ_ENABLE:  w_rdata = {{(32 - N_SRC){1'b0}}, r_enable};
      IRQ_TRIGGER: w_rdata = {{(32 - N_SRC){1'b0}}, r_trig};
      IRQ_CLAIM:   w_rdata = {26'd0, w_claimId};
      default:     w_rdata = '0;
    endcase
  end

  // Bus side: every request is acknowledged with a one-cycle pulse at the
  // edge that samples it, read data is captured at that same edge, and
  // ENABLE/TRIGGER writes land at that edge too. PENDING is read-only, so a
  // write to it only produces the ack.
  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      r_enable <= '0;
      r_trig   <= '0;
      r_rdata  <= '0;
      r_ack    <= 1'b0;
    end else begin
      r_ack <= i_BUS_EN;
      if (i_BUS_EN) begin
        r_rdata <= i_BUS_WE ? 32'd0 : w_rdata;
      end
      if (w_isWrite && (w_word == IRQ_ENABLE)) begin
        r_enable <= i_BUS_WDATA[N_SRC-1:0];
      end
      if (w_isWrite && (w_word == IRQ_TRIGGER)) begin
        r_trig <= i_BUS_WDATA[N_SRC-1:0];
      end
    end
  end

  assign o_BUS_RDATA = r_rdata;
  assign o_BUS_ACK   = r_ack;
  assign o_MEI       = w_pending & r_enable;

endmodule

// File: tb/tb_irq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_irq_ctrl
//
// Purpose: self-checking bench for irq_ctrl. Bus reads push their expected
// data into a scoreboard queue; a monitor pops and compares whenever the DUT
// acknowledges. Interrupt outputs are checked directly between accesses.
// Honours IRQ_CTRL_SYNC_EN for the expected source-to-o_MEI latency.
// ---------------------------------------------------------------------------
module tb_irq_ctrl;

  localparam int N_SRC = 6;
`ifdef IRQ_CTRL_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic             i_CLK = 1'b0;
  logic             i_RSTn = 1'b0;
  logic [N_SRC-1:0] i_SRC = '0;
  logic             i_BUS_EN = 1'b0;
  logic             i_BUS_WE = 1'b0;
  logic [3:0]       i_BUS_ADDR = '0;
  logic [31:0]      i_BUS_WDATA = '0;
  logic [31:0]      o_BUS_RDATA;
  logic             o_BUS_ACK;
  logic [N_SRC-1:0] o_MEI;

  typedef struct {
    string       tag;
    logic        isRead;
    logic [31:0] exp;
  } sbEntry_t;

  sbEntry_t sbQueue[$];
  int nChecks = 0;
  int nFails  = 0;
  int cnt;

  irq_ctrl #(.N_SRC(N_SRC)) dut (
    .i_CLK       (i_CLK),
    .i_RSTn      (i_RSTn),
    .i_SRC       (i_SRC),
    .i_BUS_EN    (i_BUS_EN),
    .i_BUS_WE    (i_BUS_WE),
    .i_BUS_ADDR  (i_BUS_ADDR),
    .i_BUS_WDATA (i_BUS_WDATA),
    .o_BUS_RDATA (o_BUS_RDATA),
    .o_BUS_ACK   (o_BUS_ACK),
    .o_MEI       (o_MEI)
  );

  always #5 i_CLK = ~i_CLK;

  // Every comparison in the bench funnels through here.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: just after each rising edge, an ack pops the oldest
  // outstanding access and, for reads, compares the returned data.
  always @(posedge i_CLK) begin
    #1;
    if (o_BUS_ACK === 1'b1) begin
      if (sbQueue.size() == 0) begin
        checkOutput("ack without request", 32'(o_BUS_ACK), 32'd0);
      end else begin
        sbEntry_t e;
        e = sbQueue.pop_front();
        if (e.isRead) begin
          checkOutput(e.tag, o_BUS_RDATA, e.exp);
        end
      end
    end
  end

  // One bus access, issued at a falling edge and sampled at the next rising
  // edge; by the following falling edge its ack must have been consumed.
  task automatic applyStimulus(input logic we, input logic [3:0] addr,
                               input logic [31:0] data,
                               input logic [31:0] expRd, input string tag);
    sbEntry_t e;
    e.tag    = tag;
    e.isRead = !we;
    e.exp    = expRd;
    sbQueue.push_back(e);
    i_BUS_EN    = 1'b1;
    i_BUS_WE    = we;
    i_BUS_ADDR  = addr;
    i_BUS_WDATA = data;
    @(negedge i_CLK);
    i_BUS_EN = 1'b0;
    i_BUS_WE = 1'b0;
    checkOutput({tag, " acked"}, 32'(sbQueue.size()), 32'd0);
  endtask

  task automatic busWrite(input logic [3:0] addr, input logic [31:0] data);
    applyStimulus(1'b1, addr, data, 32'd0, "write");
  endtask

  task automatic busRead(input logic [3:0] addr, input logic [31:0] exp,
                         input string tag);
    applyStimulus(1'b0, addr, 32'd0, exp, tag);
  endtask

  // One-cycle source pulse, then enough edges for it to reach the gateway.
  task automatic pulseSrc(input logic [N_SRC-1:0] mask);
    i_SRC = mask;
    @(negedge i_CLK);
    i_SRC = '0;
    repeat (LAT) @(negedge i_CLK);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    // Reset values while reset is held.
    #12;
    checkOutput("reset mei", 32'(o_MEI), 32'd0);
    checkOutput("reset ack", 32'(o_BUS_ACK), 32'd0);
    checkOutput("reset rdata", o_BUS_RDATA, 32'd0);
    @(negedge i_CLK);
    i_RSTn = 1'b1;
    @(negedge i_CLK);

    // Basic edge interrupt and exact latency.
    busWrite(4'h8, 32'h3F);
    busWrite(4'h4, 32'h04);
    busRead(4'h8, 32'h3F, "trigger readback");
    busRead(4'h4, 32'h04, "enable readback");
    i_SRC = 6'h04;
    @(negedge i_CLK);
    i_SRC = '0;
    cnt = 0;
    while (o_MEI == '0 && cnt < 10) begin
      @(negedge i_CLK);
      cnt++;
    end
    checkOutput("edge latency", 32'(cnt), 32'(LAT));
    checkOutput("mei src2", 32'(o_MEI), 32'h04);
    busRead(4'hC, 32'd3, "claim src2");
    checkOutput("mei after claim", 32'(o_MEI), 32'h00);
    busRead(4'h0, 32'h0, "pending while claimed");
    busWrite(4'hC, 32'd3);
    busRead(4'h0, 32'h0, "pending after complete");
    busRead(4'hC, 32'd0, "claim nothing pending");

    // Rearm: an edge during service is remembered until complete.
    busWrite(4'h4, 32'h01);
    pulseSrc(6'h01);
    checkOutput("mei src0", 32'(o_MEI), 32'h01);
    busRead(4'hC, 32'd1, "claim src0");
    checkOutput("mei src0 claimed", 32'(o_MEI), 32'h00);
    pulseSrc(6'h01);
    checkOutput("mei rearm held", 32'(o_MEI), 32'h00);
    busRead(4'h0, 32'h0, "pending rearm held");
    busWrite(4'hC, 32'd1);
    checkOutput("mei rearm fired", 32'(o_MEI), 32'h01);
    busRead(4'hC, 32'd1, "claim rearmed src0");
    busWrite(4'hC, 32'd1);
    checkOutput("mei rearm cleared", 32'(o_MEI), 32'h00);
    busRead(4'h0, 32'h0, "pending rearm cleared");

    // Illegal completes and read-only PENDING.
    pulseSrc(6'h09);
    busRead(4'hC, 32'd1, "claim src0 masked src3");
    busWrite(4'hC, 32'd0);
    busWrite(4'hC, 32'd7);
    busWrite(4'hC, 32'd4);
    busRead(4'h0, 32'h08, "pending after bad completes");
    busWrite(4'h0, 32'hFF);
    busRead(4'h0, 32'h08, "pending read-only");
    busRead(4'hC, 32'd0, "claim after bad completes");
    busWrite(4'hC, 32'd1);
    busRead(4'h0, 32'h08, "pending after good complete");
    busWrite(4'h4, 32'h08);
    checkOutput("mei src3", 32'(o_MEI), 32'h08);
    busRead(4'hC, 32'd4, "claim src3");
    busWrite(4'hC, 32'd4);

    // Priority in level mode.
    busWrite(4'h8, 32'h00);
    busWrite(4'h4, 32'h3F);
    i_SRC = 6'h30;
    repeat (LAT + 1) @(negedge i_CLK);
    checkOutput("mei level 0x30", 32'(o_MEI), 32'h30);
    busRead(4'hC, 32'd5, "priority first");
    busRead(4'hC, 32'd6, "priority second");
    busRead(4'hC, 32'd0, "priority empty");
    checkOutput("mei both claimed", 32'(o_MEI), 32'h00);
    i_SRC = '0;
    repeat (LAT + 1) @(negedge i_CLK);
    busWrite(4'hC, 32'd5);
    busWrite(4'hC, 32'd6);
    busRead(4'h0, 32'h0, "pending level released");

    // Masking keeps state but hides the request.
    busWrite(4'h8, 32'h3F);
    busWrite(4'h4, 32'h00);
    pulseSrc(6'h02);
    checkOutput("mei masked", 32'(o_MEI), 32'h00);
    busRead(4'hC, 32'd0, "claim masked");
    busRead(4'h0, 32'h02, "pending masked");
    busWrite(4'h4, 32'h02);
    checkOutput("mei unmasked", 32'(o_MEI), 32'h02);
    busRead(4'hC, 32'd2, "claim src1");
    busWrite(4'hC, 32'd2);

    // Claim and new edge at the same clock edge: claim sees pre-edge state.
    busWrite(4'h4, 32'h01);
    i_SRC = 6'h01;
    @(negedge i_CLK);
    i_SRC = '0;
    repeat (LAT - 1) @(negedge i_CLK);
    busRead(4'hC, 32'd0, "claim vs edge");
    checkOutput("mei after claim vs edge", 32'(o_MEI), 32'h01);
    busRead(4'hC, 32'd1, "claim after edge");

    // Complete and new edge at the same clock edge: source ends pending.
    i_SRC = 6'h01;
    @(negedge i_CLK);
    i_SRC = '0;
    repeat (LAT - 1) @(negedge i_CLK);
    busWrite(4'hC, 32'd1);
    checkOutput("mei complete vs edge", 32'(o_MEI), 32'h01);
    busRead(4'h0, 32'h01, "pending complete vs edge");
    busRead(4'hC, 32'd1, "claim complete vs edge");
    busWrite(4'hC, 32'd1);

    // Asynchronous reset in the middle of a claim.
    busWrite(4'h4, 32'h03);
    pulseSrc(6'h03);
    begin
      sbEntry_t e;
      e.tag    = "claim pre-reset";
      e.isRead = 1'b1;
      e.exp    = 32'd1;
      sbQueue.push_back(e);
    end
    i_BUS_EN   = 1'b1;
    i_BUS_WE   = 1'b0;
    i_BUS_ADDR = 4'hC;
    @(posedge i_CLK);
    #2;
    checkOutput("mei pre-reset", 32'(o_MEI), 32'h02);
    checkOutput("ack pre-reset", 32'(o_BUS_ACK), 32'd1);
    i_RSTn   = 1'b0;
    i_BUS_EN = 1'b0;
    #1;
    checkOutput("async reset mei", 32'(o_MEI), 32'h00);
    checkOutput("async reset ack", 32'(o_BUS_ACK), 32'd0);
    checkOutput("async reset rdata", o_BUS_RDATA, 32'd0);
    @(negedge i_CLK);
    i_RSTn = 1'b1;
    @(negedge i_CLK);
    busRead(4'h4, 32'h0, "enable after reset");
    busRead(4'h8, 32'h0, "trigger after reset");
    busRead(4'h0, 32'h0, "pending after reset");
    checkOutput("mei after reset", 32'(o_MEI), 32'h00);

    repeat (2) @(negedge i_CLK);
    checkOutput("scoreboard drained", 32'(sbQueue.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFails);
    $finish;
  end

endmodule
